// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA timing sequencer with pixel-tick divider and scaled frame-memory coordinates.
// Ports: clk, reset (sync, active-high) in; pix_tick, hsync/vsync (active-low),
//        display_en, hpixel/vpixel (memory column/row), frame_start out.
module vga_scan_controller #(
  parameter int CLK_DIV = 4,
  parameter int H_PULSE = 96,
  parameter int H_BP    = 48,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int V_PULSE = 2,
  parameter int V_BP    = 33,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int SCALE_H = 5,
  parameter int SCALE_V = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic [6:0] hpixel,
  output logic [6:0] vpixel,
  output logic       frame_start
);
  typedef enum logic [1:0] {SEG_PULSE, SEG_BP, SEG_DISP, SEG_FP} seg_t;
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0] SH_MAX = 8'(SCALE_H - 1);
  localparam logic [7:0] SV_MAX = 8'(SCALE_V - 1);
  localparam logic [6:0] HPIX_MAX = 7'(H_DISP / SCALE_H - 1);
  localparam logic [6:0] VPIX_MAX = 7'(V_DISP / SCALE_V - 1);
  function automatic logic [15:0] hlen(seg_t s);
    return s == SEG_PULSE ? 16'(H_PULSE) : s == SEG_BP ? 16'(H_BP) : s == SEG_DISP ? 16'(H_DISP) : 16'(H_FP);
  endfunction
  function automatic logic [15:0] vlen(seg_t s);
    return s == SEG_PULSE ? 16'(V_PULSE) : s == SEG_BP ? 16'(V_BP) : s == SEG_DISP ? 16'(V_DISP) : 16'(V_FP);
  endfunction
  seg_t h_q, h_d, v_q, v_d;
  logic [15:0] div_q, div_d, hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [6:0] hpix_q, hpix_d, vpix_q, vpix_d;
  logic tick, h_end, v_end, eol;
  assign tick = div_q == DIV_MAX;
  assign h_end = hcnt_q == hlen(h_q) - 16'd1;
  assign v_end = vcnt_q == vlen(v_q) - 16'd1;
  assign eol = tick && h_q == SEG_FP && h_end;
  always_comb begin
    div_d = tick ? 16'd0 : div_q + 16'd1;
    h_d = h_q;
    hcnt_d = hcnt_q;
    v_d = v_q;
    vcnt_d = vcnt_q;
    hsub_d = hsub_q;
    hpix_d = hpix_q;
    vsub_d = vsub_q;
    vpix_d = vpix_q;
    if (tick) begin
      h_d = h_end ? seg_t'(h_q + 2'd1) : h_q;
      hcnt_d = h_end ? 16'd0 : hcnt_q + 16'd1;
    end
    if (eol) begin
      v_d = v_end ? seg_t'(v_q + 2'd1) : v_q;
      vcnt_d = v_end ? 16'd0 : vcnt_q + 16'd1;
    end
    // Clearing on the leaving tick keeps hpixel at 0 for the whole blanking interval.
    if (tick) begin
      if (h_q != SEG_DISP || h_d != SEG_DISP) begin
        hsub_d = 8'd0;
        hpix_d = 7'd0;
      end else begin
        hsub_d = hsub_q == SH_MAX ? 8'd0 : hsub_q + 8'd1;
        hpix_d = (hsub_q == SH_MAX && hpix_q != HPIX_MAX) ? hpix_q + 7'd1 : hpix_q;
      end
    end
    if (eol) begin
      if (v_q != SEG_DISP || v_d != SEG_DISP) begin
        vsub_d = 8'd0;
        vpix_d = 7'd0;
      end else begin
        vsub_d = vsub_q == SV_MAX ? 8'd0 : vsub_q + 8'd1;
        vpix_d = (vsub_q == SV_MAX && vpix_q != VPIX_MAX) ? vpix_q + 7'd1 : vpix_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q <= SEG_PULSE;
      v_q <= SEG_PULSE;
      hcnt_q <= '0;
      vcnt_q <= '0;
      hsub_q <= '0;
      vsub_q <= '0;
      hpix_q <= '0;
      vpix_q <= '0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      hpix_q <= hpix_d;
      vpix_q <= vpix_d;
    end
  end
  assign pix_tick = tick;
  assign hsync = h_q != SEG_PULSE;
  assign vsync = v_q != SEG_PULSE;
  assign display_en = h_q == SEG_DISP && v_q == SEG_DISP;
  assign hpixel = hpix_q;
  assign vpixel = vpix_q;
  // First clock of the first display tick of the first display line.
  assign frame_start = h_q == SEG_DISP && hcnt_q == 16'd0 && div_q == 16'd0 &&
                       v_q == SEG_DISP && vcnt_q == 16'd0 && vsub_q == 8'd0;
endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: directed scoreboard bench for vga_scan_controller on a shrunken timing.
module tb_vga_scan_controller;
  localparam int CD = 2;
  localparam int HP = 3, HB = 2, HD = 10, HF = 2;
  localparam int VP = 2, VB = 2, VD = 6, VF = 2;
  localparam int SH = 2, SV = 2;
  localparam int LINE = HP + HB + HD + HF;
  localparam int FRAME = VP + VB + VD + VF;
  localparam int FRAME_CLK = LINE * FRAME * CD;
  logic clk = 0, reset;
  logic pix_tick, hsync, vsync, display_en, frame_start;
  logic [6:0] hpixel, vpixel;
  int total = 0, bad = 0;
  int hs_low, fs_cnt, tt;
  logic [18:0] sbq[$];
  logic [18:0] exp_v;
  bit found;
  vga_scan_controller #(
    .CLK_DIV(CD), .H_PULSE(HP), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
    .V_PULSE(VP), .V_BP(VB), .V_DISP(VD), .V_FP(VF), .SCALE_H(SH), .SCALE_V(SV)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
    .display_en(display_en), .hpixel(hpixel), .vpixel(vpixel), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [18:0] obs();
    return {pix_tick, hsync, vsync, display_en, frame_start, hpixel, vpixel};
  endfunction
  // Expected outputs t clocks after reset release, from tick/line arithmetic.
  function automatic logic [18:0] model(int t);
    int k, hp, ln, hpix, vpix;
    logic hd, vd, fs;
    k = t / CD;
    hp = k % LINE;
    ln = (k / LINE) % FRAME;
    hd = hp >= HP + HB && hp < HP + HB + HD;
    vd = ln >= VP + VB && ln < VP + VB + VD;
    hpix = hd ? (hp - HP - HB) / SH : 0;
    vpix = vd ? (ln - VP - VB) / SV : 0;
    fs = hd && vd && hp == HP + HB && t % CD == 0 && ln == VP + VB;
    return {t % CD == CD - 1, hp >= HP, ln >= VP, hd && vd, fs, 7'(hpix), 7'(vpix)};
  endfunction
  task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o == e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  // Compares n cycles starting at the cycle right after the last reset edge.
  task automatic run_from_reset(input int n);
    hs_low = 0;
    fs_cnt = 0;
    for (int t = 0; t < n; t++) begin
      sbq.push_back(model(t));
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t < LINE * CD && !hsync) hs_low++;
      if (frame_start) fs_cnt++;
      check("cycle", obs(), sbq.pop_front());
      tt = t;
    end
  endtask
  initial begin
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", obs(), 19'd0);
    reset = 0;
    run_from_reset(2 * FRAME_CLK + 4);
    check_int("hsync_low_clk", hs_low, HP * CD);
    check_int("frame_start_count", fs_cnt, 2);
    found = 0;
    for (int i = 0; i < FRAME_CLK && !found; i++) begin
      if (display_en && hpixel == 7'd2 && vpixel == 7'd1) found = 1;
      else begin
        tt++;
        sbq.push_back(model(tt));
        @(posedge clk);
        #1;
        check("seek", obs(), sbq.pop_front());
      end
    end
    check_int("mid_frame_found", int'(found), 1);
    reset = 1;
    @(posedge clk);
    #1;
    check("mid_reset", obs(), 19'd0);
    reset = 0;
    run_from_reset(FRAME_CLK + 4);
    check_int("frame_start_after_reset", fs_cnt, 1);
    check_int("hsync_low_after_reset", hs_low, HP * CD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
